// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer
// Output response analyzer for the LBIST datapath. CUT response words are
// compacted into a multiple-input signature register (MISR). After
// N_PATTERNS accepted words the final signature is compared against GOLDEN
// and done/pass are reported to the BIST controller.
//
// Handshake: a response word is accepted on every rising edge where the
// block is in COMPACT and resp_valid is high; there is no back-pressure,
// so the producer must not present more than N_PATTERNS valid words per run.
//
// The FSM state is fully visible on the outputs: busy=1 means COMPACT,
// done=1 means DONE, and busy=done=0 means IDLE.
module bist_response_analyzer #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] POLY      = 8'hB8,
  parameter logic [WIDTH-1:0] SEED      = 8'h00,
  parameter int              N_PATTERNS = 255,
  parameter logic [WIDTH-1:0] GOLDEN    = 8'h00,
  parameter int              CW         = $clog2(N_PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] signature,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPACT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  localparam logic [CW-1:0] LAST_CNT = CW'(N_PATTERNS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pass_q, pass_d;

  logic             fb;
  logic [WIDTH-1:0] sig_next;
  logic             accept;
  logic             last_accept;
  logic             launch;

  // MISR next value and the accept / launch qualifiers
  always_comb begin
    fb          = ^(sig_q & POLY);
    sig_next    = {sig_q[WIDTH-2:0], fb} ^ resp;
    accept      = (state_q == S_COMPACT) && resp_valid;
    last_accept = accept && (cnt_q == LAST_CNT);
    launch      = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  end

  // State register and datapath registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic: start is only honoured outside COMPACT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_COMPACT;
      S_COMPACT: if (last_accept) state_d = S_DONE;
      S_DONE:    if (start) state_d = S_COMPACT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values: load seed on launch, compact on accept, else hold
  always_comb begin
    sig_d  = sig_q;
    cnt_d  = cnt_q;
    pass_d = pass_q;
    if (launch) begin
      sig_d  = SEED;
      cnt_d  = '0;
      pass_d = 1'b0;
    end else if (accept) begin
      sig_d = sig_next;
      cnt_d = cnt_q + CW'(1);
      if (last_accept) pass_d = (sig_next == GOLDEN);
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    signature = sig_q;
    count     = cnt_q;
    busy      = (state_q == S_COMPACT);
    done      = (state_q == S_DONE);
    pass      = pass_q;
  end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench for bist_response_analyzer. Four instances with different
// parameters share one stimulus stream; a reference model of each predicts
// every cycle's outputs, a monitor compares them, and directed checks pin
// down the known vectors.
module tb_bist_response_analyzer;

  localparam int NDUT = 4;
  localparam int W    = 19; // {signature[7:0], count[7:0], busy, done, pass}
  localparam logic [7:0] POLY = 8'hB8;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst        = 1'b0;
  logic       start      = 1'b0;
  logic       resp_valid = 1'b0;
  logic [7:0] resp       = 8'h00;

  // DUT 0: N=255, SEED=0, GOLDEN=0
  logic [7:0] sig_m;  logic [7:0] cnt_m;  logic busy_m,  done_m,  pass_m;
  // DUT 1: N=2, SEED=0, GOLDEN=2
  logic [7:0] sig_kp; logic [1:0] cnt_kp; logic busy_kp, done_kp, pass_kp;
  // DUT 2: N=2, SEED=0, GOLDEN=3
  logic [7:0] sig_kf; logic [1:0] cnt_kf; logic busy_kf, done_kf, pass_kf;
  // DUT 3: N=1, SEED=8'h80, GOLDEN=0
  logic [7:0] sig_fb; logic [0:0] cnt_fb; logic busy_fb, done_fb, pass_fb;

  bist_response_analyzer #(.WIDTH(8), .POLY(POLY), .SEED(8'h00), .N_PATTERNS(255), .GOLDEN(8'h00)) u_main (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
    .signature(sig_m), .count(cnt_m), .busy(busy_m), .done(done_m), .pass(pass_m));

  bist_response_analyzer #(.WIDTH(8), .POLY(POLY), .SEED(8'h00), .N_PATTERNS(2), .GOLDEN(8'h02)) u_kv_pass (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
    .signature(sig_kp), .count(cnt_kp), .busy(busy_kp), .done(done_kp), .pass(pass_kp));

  bist_response_analyzer #(.WIDTH(8), .POLY(POLY), .SEED(8'h00), .N_PATTERNS(2), .GOLDEN(8'h03)) u_kv_fail (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
    .signature(sig_kf), .count(cnt_kf), .busy(busy_kf), .done(done_kf), .pass(pass_kf));

  bist_response_analyzer #(.WIDTH(8), .POLY(POLY), .SEED(8'h80), .N_PATTERNS(1), .GOLDEN(8'h00)) u_fb (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
    .signature(sig_fb), .count(cnt_fb), .busy(busy_fb), .done(done_fb), .pass(pass_fb));

  logic [W-1:0] obs [NDUT];
  assign obs[0] = {sig_m,  cnt_m,          busy_m,  done_m,  pass_m};
  assign obs[1] = {sig_kp, 6'b0, cnt_kp,   busy_kp, done_kp, pass_kp};
  assign obs[2] = {sig_kf, 6'b0, cnt_kf,   busy_kf, done_kf, pass_kf};
  assign obs[3] = {sig_fb, 7'b0, cnt_fb,   busy_fb, done_fb, pass_fb};

  // Reference model: mode 0=idle, 1=compacting, 2=done
  int         p_n    [NDUT] = '{255, 2, 2, 1};
  logic [7:0] p_seed [NDUT] = '{8'h00, 8'h00, 8'h00, 8'h80};
  logic [7:0] p_gold [NDUT] = '{8'h00, 8'h02, 8'h03, 8'h00};
  int         m_mode [NDUT];
  logic [7:0] m_sig  [NDUT];
  int         m_cnt  [NDUT];
  logic       m_pass [NDUT];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [NDUT*W-1:0] exp_q[$];

  // Signature update: shift left, feed back parity of tapped bits, xor word
  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] r);
    int ones = 0;
    int v;
    for (int i = 0; i < 8; i++) if (s[i] && POLY[i]) ones++;
    v = (int'(s) * 2 + (ones % 2)) % 256;
    return 8'(v) ^ r;
  endfunction

  function automatic void model_edge(input int d, input logic r, input logic st,
                                     input logic v, input logic [7:0] w);
    if (!r) begin
      m_mode[d] = 0; m_sig[d] = p_seed[d]; m_cnt[d] = 0; m_pass[d] = 1'b0;
    end else if (m_mode[d] != 1) begin
      if (st) begin
        m_mode[d] = 1; m_sig[d] = p_seed[d]; m_cnt[d] = 0; m_pass[d] = 1'b0;
      end
    end else if (v) begin
      m_sig[d] = misr_step(m_sig[d], w);
      m_cnt[d] = m_cnt[d] + 1;
      if (m_cnt[d] == p_n[d]) begin
        m_mode[d] = 2;
        m_pass[d] = (m_sig[d] == p_gold[d]);
      end
    end
  endfunction

  // Driver: apply one cycle of inputs and push the predicted post-edge outputs
  task automatic drive(input logic r, input logic st, input logic v, input logic [7:0] w);
    logic [NDUT*W-1:0] e;
    @(negedge clk);
    rst = r; start = st; resp_valid = v; resp = w;
    for (int d = 0; d < NDUT; d++) begin
      model_edge(d, r, st, v, w);
      e[d*W +: W] = {m_sig[d], 8'(m_cnt[d]), m_mode[d] == 1, m_mode[d] == 2, m_pass[d]};
    end
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare each instance against the popped prediction
  initial begin
    logic [NDUT*W-1:0] e;
    logic [W-1:0] x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
          x = e[d*W +: W];
          n_vec++;
          if (obs[d] !== x) begin
            n_err++;
            $display("FAIL dut%0d cycle %0d: got sig=%h cnt=%0d busy=%b done=%b pass=%b, expected sig=%h cnt=%0d busy=%b done=%b pass=%b",
                     d, cyc, obs[d][18:11], obs[d][10:3], obs[d][2], obs[d][1], obs[d][0],
                     x[18:11], x[10:3], x[2], x[1], x[0]);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int guard;

    // Reset held two cycles with start and resp_valid asserted
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
      settle();
      chk("reset_sig", 32'(sig_m), 32'h00);
      chk("reset_flags", {29'b0, busy_m, done_m, pass_m}, 32'h0);
      chk("reset_count", 32'(cnt_m), 32'h0);
    end
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
    settle();
    chk("idle_after_reset", {30'b0, busy_m, done_m}, 32'h0);

    // Known vector: start, 01, 00
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 8'h01);
    settle();
    chk("kv_sig_word1", 32'(sig_kp), 32'h01);
    chk("kv_cnt_word1", 32'(cnt_kp), 32'h1);
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    settle();
    chk("kv_sig_word2", 32'(sig_kp), 32'h02);
    chk("kv_flags_pass", {29'b0, busy_kp, done_kp, pass_kp}, 32'b011);
    chk("kv_flags_fail", {29'b0, busy_kf, done_kf, pass_kf}, 32'b010);
    chk("kv_fail_sig", 32'(sig_kf), 32'h02);

    // Feedback path on the N=1 instance: start, 00
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    settle();
    chk("fb_seed", 32'(sig_fb), 32'h80);
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    settle();
    chk("fb_sig", 32'(sig_fb), 32'h01);
    chk("fb_done", 32'(done_fb), 32'h1);

    // Gaps and ignored start pulses on a full all-zero run
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    guard = 0;
    while (m_mode[0] != 2 && guard < 2000) begin
      drive(1'b1, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 8'h00);
      guard++;
    end
    chk("gap_run_bound", 32'(m_mode[0] == 2), 32'h1);
    settle();
    chk("gap_count", 32'(cnt_m), 32'd255);
    chk("gap_sig", 32'(sig_m), 32'h00);
    chk("gap_done_pass", {29'b0, busy_m, done_m, pass_m}, 32'b011);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
    settle();
    chk("done_count_hold", 32'(cnt_m), 32'd255);
    chk("done_sig_hold", 32'(sig_m), 32'h00);

    // Restart from DONE
    drive(1'b1, 1'b1, 1'b1, 8'($urandom_range(1, 255)));
    settle();
    chk("restart_flags", {29'b0, busy_m, done_m, pass_m}, 32'b100);
    chk("restart_count", 32'(cnt_m), 32'h0);
    chk("restart_sig", 32'(sig_m), 32'h00);

    // Reset after ten accepted random words
    guard = 0;
    while (m_cnt[0] < 10 && guard < 200) begin
      drive(1'b1, 1'b0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
      guard++;
    end
    drive(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
    settle();
    chk("midrst_sig", 32'(sig_m), 32'h00);
    chk("midrst_count", 32'(cnt_m), 32'h0);
    chk("midrst_flags", {30'b0, busy_m, done_m}, 32'h0);

    // Fresh random run to completion
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    guard = 0;
    while (m_mode[0] != 2 && guard < 2000) begin
      drive(1'b1, $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0, 8'($urandom_range(0, 255)));
      guard++;
    end
    chk("rand_run_bound", 32'(m_mode[0] == 2), 32'h1);
    settle();
    chk("rand_done", 32'(done_m), 32'h1);
    chk("rand_count", 32'(cnt_m), 32'd255);

    // Unconstrained random traffic including occasional resets
    for (int k = 0; k < 300; k++)
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));

    drive(1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    settle();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bist_response_analyzer.md
# bist_response_analyzer

Output response analyzer (ORA) for the LBIST datapath. It is the consuming end of the pattern path: the pattern counter and generator drive stimulus into the circuit under test, and this block compacts the CUT responses into a multiple-input signature register (MISR). It counts accepted responses and, after a programmed test length, compares the final signature against a golden value. It then reports done and pass/fail to the BIST controller.

## Interface
- WIDTH, 8, response and signature width in bits (≥ 2)
- POLY, 8'hB8, MISR feedback tap mask; bit i set means sig[i] feeds the parity feedback
- SEED, 8'h00, signature value loaded on start
- N_PATTERNS, 255, number of responses compacted per run (≥ 1)
- GOLDEN, 8'h00, expected final signature
- CW, $clog2(N_PATTERNS+1), width of the count output (derived)
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- start  input  1  begins a run when sampled high in IDLE or DONE
- resp_valid  input  1  resp is valid this cycle
- resp  input  WIDTH  CUT response word
- signature  output  WIDTH  current MISR contents
- count  output  CW  responses accepted in the current run
- busy  output  1  high in COMPACT
- done  output  1  high in DONE
- pass  output  1  valid only while done=1; 1 when the final signature equals GOLDEN

## Operation
- FSM has three states: IDLE, COMPACT, DONE.
- Reset (rst=0 at a clock edge) forces:
  - state to IDLE
  - signature to SEED, count to 0
  - busy, done and pass to 0
- Reset has priority over every other input, including in mid-run.
- IDLE or DONE with start=1: load signature to SEED, clear count and pass, go to COMPACT. resp_valid is ignored in that cycle.
- COMPACT with resp_valid=0: all state holds.
- COMPACT with resp_valid=1: accept one word.
  - fb = ^(signature & POLY)
  - signature_next = {signature[WIDTH-2:0], fb} ^ resp
  - count increments by 1
- Final accept: when resp_valid=1 and count == N_PATTERNS-1:
  - signature takes signature_next and count becomes N_PATTERNS
  - state goes to DONE
  - pass <= (signature_next == GOLDEN)
- In COMPACT, start is ignored; a run is never restarted mid-compaction.
- DONE: signature, count and pass hold, and resp_valid is ignored. Leaving DONE requires start or reset.
- count never exceeds N_PATTERNS; there is no wrap-around.

## Timing
- All outputs are registered; none is combinational from inputs.
- start sampled high at edge k gives busy=1 and signature=SEED after edge k.
- Each accepted word updates signature and count at the edge where resp_valid is sampled high, i.e. one cycle of latency.
- done and pass become valid after the edge that accepts word N_PATTERNS. busy falls at the same edge.
- Gaps in resp_valid only stretch the run; the final signature does not depend on gap placement.
- Back-to-back runs: start in DONE begins a new run at the next edge. Minimum spacing between runs is N_PATTERNS+1 cycles.

## Test plan
- Reset behaviour: hold rst=0 for 2 cycles with start=1 and resp_valid=1.
  - Required: signature=SEED, count=0, busy=done=pass=0 throughout.
  - After release with start=0, the block stays in IDLE.
- Known vector (N_PATTERNS=2, SEED=8'h00, POLY=8'hB8, GOLDEN=8'h02): start, then resp 8'h01, then 8'h00 on consecutive valid cycles.
  - Required: signature 8'h01 after the first word, 8'h02 after the second.
  - done=1, pass=1, busy=0.
  - Same run with GOLDEN=8'h03: pass=0.
- Feedback path (N_PATTERNS=1, SEED=8'h80): start, then resp 8'h00.
  - Required: signature 8'h01 (fb=1), done=1.
- Gaps and ignored inputs (N_PATTERNS=255, all-zero responses, SEED=0):
  - Insert random resp_valid=0 gaps and pulse start mid-run.
  - Required: the run is not restarted; count=255 at done; signature=8'h00; pass=1 with GOLDEN=0.
  - count holds at 255 when resp_valid continues in DONE.
- Reset mid-run: assert rst=0 after 10 accepted words.
  - Required: IDLE on the next edge, signature=SEED, count=0, done=0.
  - A fresh start then completes normally.
- Restart from DONE: assert start while done=1.
  - Required: done=0, pass=0, busy=1, count=0, signature=SEED after the next edge.
